// File: rtl/usb_fs_host_tx.sv
// Full-speed USB host-side packet transmitter.
// Serialises a valid/ready byte stream onto D+/D- with SYNC, LSB-first NRZI,
// bit stuffing and EOP.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | bus released (oe=0, line J), waiting for the PID byte
// SYNC    | sending 0x80 LSB first (KJKJKJKK)
// DATA    | sending packet bytes, inserting stuffed zeros as needed
// EOP_SE0 | two bit times of SE0
// EOP_J   | one bit time of J, then release the bus
module usb_fs_host_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int STUFF_LEN    = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       busy,
   output logic       underrun,
   output logic       dp,
   output logic       dm,
   output logic       oe
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int OW = $clog2(STUFF_LEN + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SYNC    = 3'd1,
      DATA    = 3'd2,
      EOP_SE0 = 3'd3,
      EOP_J   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   // bit_idx is the SYNC bit, data bit or EOP SE0 bit currently on the line.
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            last_q, last_d;
   // Number of consecutive ones already on the line, including the current bit.
   logic [OW-1:0]   ones_q, ones_d;
   logic            dp_q, dp_d, dm_q, dm_d, oe_q, oe_d;
   logic            bit_end;
   logic            emit, emit_val;
   logic [2:0]      nxt_idx;

   assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));

   // State and datapath registers; reset leaves the line in J with the bus released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         last_q    <= 1'b0;
         ones_q    <= '0;
         dp_q      <= 1'b1;
         dm_q      <= 1'b0;
         oe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         last_q    <= last_d;
         ones_q    <= ones_d;
         dp_q      <= dp_d;
         dm_q      <= dm_d;
         oe_q      <= oe_d;
      end
   end

   // Next-state decode; the line only moves when the bit timer wraps.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      last_d    = last_q;
      ones_d    = ones_q;
      dp_d      = dp_q;
      dm_d      = dm_q;
      oe_d      = oe_q;
      tx_ready  = 1'b0;
      underrun  = 1'b0;
      emit      = 1'b0;
      emit_val  = 1'b0;
      nxt_idx   = bit_idx_q + 3'd1;

      if (state_q != IDLE)
         timer_d = bit_end ? '0 : timer_q + 1'b1;

      unique case (state_q)
         IDLE: begin
            if (tx_valid) begin
               tx_ready  = 1'b1;
               shreg_d   = tx_data;
               last_d    = tx_last;
               state_d   = SYNC;
               timer_d   = '0;
               bit_idx_d = '0;
               ones_d    = '0;
               oe_d      = 1'b1;
               emit      = 1'b1;   // first SYNC zero: J -> K
               emit_val  = 1'b0;
            end
         end
         SYNC: begin
            if (bit_end) begin
               emit = 1'b1;
               if (bit_idx_q != 3'd7) begin
                  bit_idx_d = nxt_idx;
                  emit_val  = (nxt_idx == 3'd7);
               end else begin
                  state_d   = DATA;
                  bit_idx_d = '0;
                  emit_val  = shreg_q[0];
               end
            end
         end
         DATA: begin
            if (bit_end) begin
               if (ones_q == OW'(STUFF_LEN)) begin
                  // Stuffed zero; the data pointer holds.
                  emit     = 1'b1;
                  emit_val = 1'b0;
               end else if (bit_idx_q != 3'd7) begin
                  bit_idx_d = nxt_idx;
                  emit      = 1'b1;
                  emit_val  = shreg_q[nxt_idx];
               end else if (last_q) begin
                  state_d   = EOP_SE0;
                  bit_idx_d = '0;
                  dp_d      = 1'b0;
                  dm_d      = 1'b0;
               end else if (tx_valid) begin
                  // Seamless reload: the next byte's bit 0 follows bit 7 directly.
                  tx_ready  = 1'b1;
                  shreg_d   = tx_data;
                  last_d    = tx_last;
                  bit_idx_d = '0;
                  emit      = 1'b1;
                  emit_val  = tx_data[0];
               end else begin
                  underrun  = 1'b1;
                  state_d   = EOP_SE0;
                  bit_idx_d = '0;
                  dp_d      = 1'b0;
                  dm_d      = 1'b0;
               end
            end
         end
         EOP_SE0: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd1) begin
                  state_d = EOP_J;
                  dp_d    = 1'b1;
                  dm_d    = 1'b0;
               end else begin
                  bit_idx_d = nxt_idx;
               end
            end
         end
         EOP_J: begin
            if (bit_end) begin
               state_d   = IDLE;
               oe_d      = 1'b0;
               dp_d      = 1'b1;
               dm_d      = 1'b0;
               bit_idx_d = '0;
               ones_d    = '0;
               timer_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // NRZI: a zero toggles J/K and breaks the run of ones, a one holds the line.
      if (emit) begin
         if (!emit_val) begin
            dp_d   = ~dp_q;
            dm_d   = ~dm_q;
            ones_d = '0;
         end else begin
            ones_d = ones_q + 1'b1;
         end
      end

      // The handshake strobes stay quiet while reset is asserted.
      if (rst) begin
         tx_ready = 1'b0;
         underrun = 1'b0;
      end
   end

   assign busy = (state_q != IDLE);
   assign dp   = dp_q;
   assign dm   = dm_q;
   assign oe   = oe_q;

endmodule
